// File: rtl/pad_od_bank.sv
// Bank of open-drain pad channels: registered drive, synchronised and glitch-filtered
// input with edge pulses, and a stuck-high fault monitor built only when PAD_OD_FAULT_EN is defined.
module pad_od_bank #(
    parameter int N_CH        = 2,
    parameter int SYNC_STAGES = 2,
    parameter int FILT_CYC    = 3,
    parameter int FAULT_CYC   = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] core_out,
    output logic [N_CH-1:0] pad_en,
    output logic [N_CH-1:0] pad_dout,
    input  logic [N_CH-1:0] pad_din,
    output logic [N_CH-1:0] core_in,
    output logic [N_CH-1:0] rise,
    output logic [N_CH-1:0] fall,
    output logic [N_CH-1:0] fault,
    input  logic [N_CH-1:0] fault_clr
);

    logic [SYNC_STAGES-1:0][N_CH-1:0] sync_q;
    logic [N_CH-1:0]                  s;
    logic [N_CH-1:0]                  core_in_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            pad_en   <= '0;
            pad_dout <= '1;
        end else begin
            pad_en   <= ~core_out;
            pad_dout <= core_out;
        end
    end

    // sync_q[0] is the stage nearest the pad; everything resets to the released level
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pad_din};
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    generate
        if (FILT_CYC == 0) begin : g_bypass
            assign core_in = s;
        end else begin : g_filt
            localparam int FW = $clog2(FILT_CYC + 1);
            localparam logic [FW-1:0] CNT_LAST = FW'(FILT_CYC - 1);

            logic [N_CH-1:0][FW-1:0] cnt;

            always_ff @(posedge clk) begin
                if (rst) begin
                    cnt     <= '0;
                    core_in <= '1;
                end else begin
                    for (int i = 0; i < N_CH; i++) begin
                        if (s[i] == core_in[i]) begin
                            cnt[i] <= '0;
                        end else if (cnt[i] == CNT_LAST) begin
                            core_in[i] <= s[i];
                            cnt[i]     <= '0;
                        end else begin
                            cnt[i] <= cnt[i] + 1'b1;
                        end
                    end
                end
            end
        end
    endgenerate

    // Resetting to 1 matches the core_in reset level, so no pulse on reset entry/exit
    always_ff @(posedge clk) begin
        if (rst) begin
            core_in_q <= '1;
        end else begin
            core_in_q <= core_in;
        end
    end

    assign rise = core_in & ~core_in_q;
    assign fall = ~core_in & core_in_q;

`ifdef PAD_OD_FAULT_EN
    localparam int CW = $clog2(FAULT_CYC + 1);
    localparam logic [CW-1:0] FCNT_MAX = CW'(FAULT_CYC);

    logic [N_CH-1:0][CW-1:0] fcnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            fcnt  <= '0;
            fault <= '0;
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                if (fault_clr[i]) begin
                    fcnt[i]  <= '0;
                    fault[i] <= 1'b0;
                end else if (pad_en[i] && core_in[i]) begin
                    if (fcnt[i] != FCNT_MAX) begin
                        fcnt[i] <= fcnt[i] + 1'b1;
                    end
                    if (fcnt[i] == FCNT_MAX - 1'b1) begin
                        fault[i] <= 1'b1;
                    end
                end else begin
                    fcnt[i] <= '0;
                end
            end
        end
    end
`else
    logic unused_fault_clr;

    assign fault            = '0;
    assign unused_fault_clr = ^fault_clr;
`endif

endmodule

// File: tb/tb_pad_od_bank.sv
// Directed + randomized bench for pad_od_bank; outputs compared every cycle against a
// window/run-length reference model, plus explicit latency and boundary checks.
module tb_pad_od_bank;

    localparam int N    = 2;
    localparam int SYNC = 2;
    localparam int FILT = 3;
    localparam int FCYC = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] core_out, pad_din, fault_clr;
    logic [N-1:0] pad_en, pad_dout, core_in, rise, fall, fault;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model state
    logic [N-1:0] m_pad_en, m_pad_dout, m_core_in, m_rise, m_fall, m_fault;
    logic [N-1:0] din_q[$];  // pad_din samples, newest first
    logic [N-1:0] s_win[$];  // last FILT synchronised samples seen by the filter, newest first
    int           run[N];    // consecutive "driving low but reading high" cycles

    pad_od_bank #(.N_CH(N), .SYNC_STAGES(SYNC), .FILT_CYC(FILT), .FAULT_CYC(FCYC)) dut (
        .clk(clk), .rst(rst), .core_out(core_out), .pad_en(pad_en), .pad_dout(pad_dout),
        .pad_din(pad_din), .core_in(core_in), .rise(rise), .fall(fall),
        .fault(fault), .fault_clr(fault_clr)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        din_q = {};
        s_win = {};
        for (int k = 0; k < SYNC; k++) din_q.push_front('1);
        for (int k = 0; k < FILT; k++) s_win.push_front('1);
        m_pad_en   = '0;
        m_pad_dout = '1;
        m_core_in  = '1;
        m_rise     = '0;
        m_fall     = '0;
        m_fault    = '0;
        for (int i = 0; i < N; i++) run[i] = 0;
    endtask

    task automatic model_edge();
        logic [N-1:0] s_old, ci_old, en_old;
        bit           flip;
        if (rst) begin
            model_reset();
        end else begin
            s_old  = din_q[SYNC-1];
            ci_old = m_core_in;
            en_old = m_pad_en;
            m_pad_en   = ~core_out;
            m_pad_dout = core_out;
            din_q.push_front(pad_din);
            void'(din_q.pop_back());
            s_win.push_front(s_old);
            void'(s_win.pop_back());
            // level changes once FILT consecutive samples disagree with it
            for (int i = 0; i < N; i++) begin
                flip = 1'b1;
                foreach (s_win[k]) if (s_win[k][i] == ci_old[i]) flip = 1'b0;
                if (flip) m_core_in[i] = s_old[i];
            end
            m_rise = m_core_in & ~ci_old;
            m_fall = ~m_core_in & ci_old;
`ifdef PAD_OD_FAULT_EN
            for (int i = 0; i < N; i++) begin
                if (fault_clr[i]) begin
                    run[i]     = 0;
                    m_fault[i] = 1'b0;
                end else if (en_old[i] && ci_old[i]) begin
                    if (run[i] < FCYC) run[i]++;
                    if (run[i] >= FCYC) m_fault[i] = 1'b1;
                end else begin
                    run[i] = 0;
                end
            end
`endif
        end
    endtask

    task automatic check_all(input string tag);
        n_checks++;
        assert (pad_en === m_pad_en) else begin
            n_fail++; $error("FAIL %s pad_en observed=%b expected=%b", tag, pad_en, m_pad_en);
        end
        n_checks++;
        assert (pad_dout === m_pad_dout) else begin
            n_fail++; $error("FAIL %s pad_dout observed=%b expected=%b", tag, pad_dout, m_pad_dout);
        end
        n_checks++;
        assert (core_in === m_core_in) else begin
            n_fail++; $error("FAIL %s core_in observed=%b expected=%b", tag, core_in, m_core_in);
        end
        n_checks++;
        assert (rise === m_rise) else begin
            n_fail++; $error("FAIL %s rise observed=%b expected=%b", tag, rise, m_rise);
        end
        n_checks++;
        assert (fall === m_fall) else begin
            n_fail++; $error("FAIL %s fall observed=%b expected=%b", tag, fall, m_fall);
        end
        n_checks++;
        assert (fault === m_fault) else begin
            n_fail++; $error("FAIL %s fault observed=%b expected=%b", tag, fault, m_fault);
        end
    endtask

    task automatic expect_int(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++; $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    initial begin
        int lat, seen, n_low, n_fall, n_rise;
        model_reset();

        // 1. reset with arbitrary inputs
        rst = 1'b1; core_out = 2'b01; pad_din = 2'b00; fault_clr = 2'b10;
        tick("reset0");
        core_out = 2'b10; pad_din = 2'b01;
        tick("reset1");
        expect_int("rst_pad_en", int'(pad_en), 0);
        expect_int("rst_pad_dout", int'(pad_dout), 3);
        expect_int("rst_core_in", int'(core_in), 3);
        expect_int("rst_pulses", int'({rise, fall, fault}), 0);
        rst = 1'b0; core_out = 2'b11; pad_din = 2'b11; fault_clr = 2'b00;
        repeat (4) tick("rst_exit");

        // 2. drive low and loop back
        core_out = 2'b10;
        tick("drive");
        expect_int("drive_pad_en", int'(pad_en), 1);
        expect_int("drive_pad_dout", int'(pad_dout), 2);
        pad_din = 2'b10;
        lat = -1; seen = 0;
        for (int k = 1; k <= 10; k++) begin
            tick("loop_fall");
            if (lat < 0 && core_in[0] === 1'b0) begin lat = k; seen = int'(fall[0]); end
        end
        expect_int("fall_latency", lat, 5);
        expect_int("fall_pulse", seen, 1);
        core_out = 2'b11;
        tick("release");
        pad_din = 2'b11;
        lat = -1; seen = 0;
        for (int k = 1; k <= 10; k++) begin
            tick("loop_rise");
            if (lat < 0 && core_in[0] === 1'b1) begin lat = k; seen = int'(rise[0]); end
        end
        expect_int("rise_latency", lat, 5);
        expect_int("rise_pulse", seen, 1);

        // 3. glitch reject then minimum accepted pulse on channel 1
        pad_din = 2'b01;
        repeat (2) tick("glitch2");
        pad_din = 2'b11;
        n_low = 0; n_fall = 0;
        for (int k = 0; k < 8; k++) begin
            tick("glitch2_after");
            if (core_in[1] === 1'b0) n_low++;
            if (fall[1] === 1'b1) n_fall++;
        end
        expect_int("glitch2_low", n_low, 0);
        expect_int("glitch2_fall", n_fall, 0);
        pad_din = 2'b01;
        n_low = 0; n_fall = 0; n_rise = 0;
        for (int k = 0; k < 14; k++) begin
            if (k == 3) pad_din = 2'b11;
            tick("glitch3");
            if (core_in[1] === 1'b0) n_low++;
            if (fall[1] === 1'b1) n_fall++;
            if (rise[1] === 1'b1) n_rise++;
        end
        expect_int("glitch3_low", n_low, 3);
        expect_int("glitch3_fall", n_fall, 1);
        expect_int("glitch3_rise", n_rise, 1);

        // 4. stuck-high fault on channel 0
        core_out = 2'b10; pad_din = 2'b11;
        tick("fault_drive");
        lat = -1;
        for (int k = 1; k <= 20; k++) begin
            tick("fault_count");
            if (lat < 0 && fault[0] === 1'b1) lat = k;
        end
`ifdef PAD_OD_FAULT_EN
        expect_int("fault_set_cycle", lat, 16);
`else
        expect_int("fault_set_cycle", lat, -1);
`endif
        fault_clr = 2'b01;
        tick("fault_clr");
        fault_clr = 2'b00;
        expect_int("fault_cleared", int'(fault[0]), 0);
        repeat (15) tick("fault_recount");
        fault_clr = 2'b01;
        tick("clr_on_set");
        fault_clr = 2'b00;
        expect_int("clr_wins", int'(fault[0]), 0);
        repeat (20) tick("fault_reset_again");

        // 5. reset in the middle of a filter run
        core_out = 2'b11; pad_din = 2'b11;
        repeat (6) tick("settle");
        pad_din = 2'b10;
        repeat (3) tick("mid_filter");
        rst = 1'b1;
        tick("mid_rst");
        rst = 1'b0; pad_din = 2'b11;
        n_fall = 0;
        for (int k = 0; k < 8; k++) begin
            tick("post_rst");
            if ((rise | fall) !== 2'b00) n_fall++;
        end
        expect_int("post_rst_pulses", n_fall, 0);

        // 6. randomized traffic
        for (int k = 0; k < 2500; k++) begin
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 15) == 0) core_out[i] = ~core_out[i];
                if ($urandom_range(0, 5) == 0) pad_din[i] = ~pad_din[i];
                fault_clr[i] = ($urandom_range(0, 40) == 0);
            end
            rst = ($urandom_range(0, 400) == 0);
            tick("random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
